// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: decodes the instruction in D, tracks the two older in-flight
// destination tags, issues to EX with operand-source selects, and stalls on unresolvable RAW hazards.
module hazard_ctrl #(
  parameter int CNT_W  = 16,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      d_IR,
  input  logic             d_valid,
  output logic             stall,
  output logic [31:0]      e_IR,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_MM = 2'b01;
  localparam logic [1:0] SEL_WB = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] r;
  } tag_t;

  tag_t       ex_tag, mm_tag;
  logic       ex_ld;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       src_a_v, src_b_v, is_ld;
  tag_t       dst_raw, dst;

  assign op    = d_IR[31:26];
  assign rs    = d_IR[25:21];
  assign rt    = d_IR[20:16];
  assign rd    = d_IR[15:11];
  assign funct = d_IR[5:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    src_a_v = 1'b0;
    src_b_v = 1'b0;
    is_ld   = 1'b0;
    dst_raw = '0;
    unique case (op)
      OP_RTYPE: if (funct == FN_ADD || funct == FN_SUB) begin
        src_a_v = 1'b1;
        src_b_v = 1'b1;
        dst_raw = '{valid: 1'b1, r: rd};
      end
      OP_ADDI: begin
        src_a_v = 1'b1;
        dst_raw = '{valid: 1'b1, r: rt};
      end
      OP_LW: begin
        src_a_v = 1'b1;
        is_ld   = 1'b1;
        dst_raw = '{valid: 1'b1, r: rt};
      end
      OP_SW: begin
        src_a_v = 1'b1;
        src_b_v = 1'b1;
      end
      default: ;
    endcase
  end

  // $0 is hardwired, so writing it produces nothing a consumer could depend on.
  assign dst = '{valid: dst_raw.valid && (dst_raw.r != 5'd0), r: dst_raw.r};

  function automatic logic match(input logic v, input logic [4:0] s, input tag_t t);
    return v && t.valid && (t.r == s) && (s != 5'd0);
  endfunction

  logic ex_a, ex_b, mm_a, mm_b, hazard, issue;

  assign ex_a = match(src_a_v, rs, ex_tag);
  assign ex_b = match(src_b_v, rt, ex_tag);
  assign mm_a = match(src_a_v, rs, mm_tag);
  assign mm_b = match(src_b_v, rt, mm_tag);

  // Without forwarding the write-through register file covers the WB producer only.
  assign hazard = FWD_EN ? ((ex_a || ex_b) && ex_ld) : (ex_a || ex_b || mm_a || mm_b);
  // Tags are cleared only at the reset edge, so stall is masked during the reset cycle itself.
  assign stall  = !reset && d_valid && hazard;
  assign issue  = d_valid && !stall;

  // The EX producer is newer than the MM producer, so it takes priority.
  function automatic logic [1:0] fwd_sel(input logic at_ex, input logic at_mm);
    if (!FWD_EN) return SEL_RF;
    if (at_ex)   return SEL_MM;
    if (at_mm)   return SEL_WB;
    return SEL_RF;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_tag    <= '0;
      mm_tag    <= '0;
      ex_ld     <= 1'b0;
      e_IR      <= '0;
      fwd_a     <= SEL_RF;
      fwd_b     <= SEL_RF;
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      mm_tag <= ex_tag;
      if (issue) begin
        ex_tag <= dst;
        ex_ld  <= is_ld;
        e_IR   <= d_IR;
        fwd_a  <= fwd_sel(ex_a, mm_a);
        fwd_b  <= fwd_sel(ex_b, mm_b);
        if (!(&issue_cnt)) issue_cnt <= issue_cnt + CNT_W'(1);
      end else begin
        ex_tag <= '0;
        ex_ld  <= 1'b0;
        e_IR   <= '0;
        fwd_a  <= SEL_RF;
        fwd_b  <= SEL_RF;
      end
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, no-forwarding and narrow-counter instances
// driven one at a time with hand-computed expected values.
module tb_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Forwarding instance
  logic [31:0] d_ir_f = '0, e_ir_f;
  logic        d_valid_f = 1'b0, stall_f;
  logic [1:0]  fwd_a_f, fwd_b_f;
  logic [15:0] issue_cnt_f, stall_cnt_f;

  // No-forwarding instance
  logic [31:0] d_ir_n = '0, e_ir_n;
  logic        d_valid_n = 1'b0, stall_n;
  logic [1:0]  fwd_a_n, fwd_b_n;
  logic [15:0] issue_cnt_n, stall_cnt_n;

  // Two-bit counter instance for saturation
  logic [31:0] d_ir_s = '0, e_ir_s;
  logic        d_valid_s = 1'b0, stall_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic [1:0]  issue_cnt_s, stall_cnt_s;

  hazard_ctrl #(.CNT_W(16), .FWD_EN(1'b1)) dut_f (
    .clock(clock), .reset(reset), .d_IR(d_ir_f), .d_valid(d_valid_f), .stall(stall_f),
    .e_IR(e_ir_f), .fwd_a(fwd_a_f), .fwd_b(fwd_b_f), .issue_cnt(issue_cnt_f), .stall_cnt(stall_cnt_f));

  hazard_ctrl #(.CNT_W(16), .FWD_EN(1'b0)) dut_n (
    .clock(clock), .reset(reset), .d_IR(d_ir_n), .d_valid(d_valid_n), .stall(stall_n),
    .e_IR(e_ir_n), .fwd_a(fwd_a_n), .fwd_b(fwd_b_n), .issue_cnt(issue_cnt_n), .stall_cnt(stall_cnt_n));

  hazard_ctrl #(.CNT_W(2), .FWD_EN(1'b1)) dut_s (
    .clock(clock), .reset(reset), .d_IR(d_ir_s), .d_valid(d_valid_s), .stall(stall_s),
    .e_IR(e_ir_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .issue_cnt(issue_cnt_s), .stall_cnt(stall_cnt_s));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_addi(input int rt, input int rs, input int imm);
    return {6'b001000, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_add(input int rd, input int rs, input int rt);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'b100000};
  endfunction
  function automatic logic [31:0] enc_sub(input int rd, input int rs, input int rt);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'b100010};
  endfunction
  function automatic logic [31:0] enc_lw(input int rt, input int rs, input int off);
    return {6'b100011, 5'(rs), 5'(rt), 16'(off)};
  endfunction
  function automatic logic [31:0] enc_sw(input int rt, input int rs, input int off);
    return {6'b101011, 5'(rs), 5'(rt), 16'(off)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic put_f(input logic [31:0] ir, input logic v);
    d_ir_f = ir; d_valid_f = v; #1;
  endtask
  task automatic put_n(input logic [31:0] ir, input logic v);
    d_ir_n = ir; d_valid_n = v; #1;
  endtask
  task automatic put_s(input logic [31:0] ir, input logic v);
    d_ir_s = ir; d_valid_s = v; #1;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_e_ir",  e_ir_f, 32'h0);
    chk("rst_fwd_a", 32'(fwd_a_f), 32'h0);
    chk("rst_fwd_b", 32'(fwd_b_f), 32'h0);
    chk("rst_issue", 32'(issue_cnt_f), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt_f), 32'h0);
    chk("rst_stall", 32'(stall_f), 32'h0);
    reset = 1'b0;

    // addi $1 then add $2,$1,$1: back-to-back, forwarded from MM
    put_f(enc_addi(1, 0, 5), 1'b1);
    chk("t1_addi_stall", 32'(stall_f), 32'h0);
    tick();
    chk("t1_addi_e_ir", e_ir_f, enc_addi(1, 0, 5));
    chk("t1_addi_fwd_a", 32'(fwd_a_f), 32'h0);
    chk("t1_addi_issue", 32'(issue_cnt_f), 32'd1);
    put_f(enc_add(2, 1, 1), 1'b1);
    chk("t1_add_stall", 32'(stall_f), 32'h0);
    tick();
    chk("t1_add_e_ir", e_ir_f, enc_add(2, 1, 1));
    chk("t1_add_fwd_a", 32'(fwd_a_f), 32'h1);
    chk("t1_add_fwd_b", 32'(fwd_b_f), 32'h1);
    put_f(32'h0, 1'b0);
    tick();
    chk("t1_bubble_e_ir", e_ir_f, 32'h0);
    chk("t1_bubble_fwd_a", 32'(fwd_a_f), 32'h0);
    chk("t1_bubble_issue", 32'(issue_cnt_f), 32'd2);

    // addi $1 ; nop ; sub $3,$1,$4: forwarded from WB
    do_reset();
    put_f(enc_addi(1, 0, 5), 1'b1);
    tick();
    put_f(32'h0, 1'b1);
    tick();
    put_f(enc_sub(3, 1, 4), 1'b1);
    chk("t2_sub_stall", 32'(stall_f), 32'h0);
    tick();
    chk("t2_sub_e_ir", e_ir_f, enc_sub(3, 1, 4));
    chk("t2_sub_fwd_a", 32'(fwd_a_f), 32'h2);
    chk("t2_sub_fwd_b", 32'(fwd_b_f), 32'h0);
    chk("t2_issue", 32'(issue_cnt_f), 32'd3);
    chk("t2_stall_cnt", 32'(stall_cnt_f), 32'd0);

    // lw $5 then addi $6,$5,1: one load-use stall then WB forward
    do_reset();
    put_f(enc_lw(5, 1, 0), 1'b1);
    tick();
    chk("t3_lw_e_ir", e_ir_f, enc_lw(5, 1, 0));
    put_f(enc_addi(6, 5, 1), 1'b1);
    chk("t3_lu_stall", 32'(stall_f), 32'h1);
    tick();
    chk("t3_bubble_e_ir", e_ir_f, 32'h0);
    chk("t3_bubble_fwd_a", 32'(fwd_a_f), 32'h0);
    chk("t3_stall_cnt1", 32'(stall_cnt_f), 32'd1);
    chk("t3_issue1", 32'(issue_cnt_f), 32'd1);
    chk("t3_stall_released", 32'(stall_f), 32'h0);
    tick();
    chk("t3_addi_e_ir", e_ir_f, enc_addi(6, 5, 1));
    chk("t3_addi_fwd_a", 32'(fwd_a_f), 32'h2);
    chk("t3_issue2", 32'(issue_cnt_f), 32'd2);
    chk("t3_stall_cnt_hold", 32'(stall_cnt_f), 32'd1);

    // $0 never matches
    put_f(enc_addi(0, 0, 7), 1'b1);
    chk("t4_addi0_stall", 32'(stall_f), 32'h0);
    tick();
    put_f(enc_add(2, 0, 0), 1'b1);
    chk("t4_add0_stall", 32'(stall_f), 32'h0);
    tick();
    chk("t4_add0_e_ir", e_ir_f, enc_add(2, 0, 0));
    chk("t4_add0_fwd_a", 32'(fwd_a_f), 32'h0);
    chk("t4_add0_fwd_b", 32'(fwd_b_f), 32'h0);

    // sw $1,0($3) after addi $1: store data forwarded from MM
    put_f(enc_addi(1, 0, 3), 1'b1);
    tick();
    put_f(enc_sw(1, 3, 0), 1'b1);
    chk("t5_sw_stall", 32'(stall_f), 32'h0);
    tick();
    chk("t5_sw_fwd_a", 32'(fwd_a_f), 32'h0);
    chk("t5_sw_fwd_b", 32'(fwd_b_f), 32'h1);

    // Reset during a load-use stall
    put_f(enc_lw(7, 0, 0), 1'b1);
    tick();
    put_f(enc_addi(8, 7, 0), 1'b1);
    chk("t6_pre_stall", 32'(stall_f), 32'h1);
    reset = 1'b1;
    #1;
    chk("t6_stall_in_reset", 32'(stall_f), 32'h0);
    tick();
    chk("t6_rst_e_ir", e_ir_f, 32'h0);
    chk("t6_rst_issue", 32'(issue_cnt_f), 32'h0);
    chk("t6_rst_stall_cnt", 32'(stall_cnt_f), 32'h0);
    reset = 1'b0;
    #1;
    chk("t6_post_stall", 32'(stall_f), 32'h0);
    tick();
    chk("t6_post_e_ir", e_ir_f, enc_addi(8, 7, 0));
    chk("t6_post_fwd_a", 32'(fwd_a_f), 32'h0);
    chk("t6_post_issue", 32'(issue_cnt_f), 32'd1);
    put_f(32'h0, 1'b0);

    // No forwarding: two stall cycles, then read from register file
    do_reset();
    put_n(enc_addi(1, 0, 1), 1'b1);
    tick();
    put_n(enc_add(2, 1, 0), 1'b1);
    chk("t7_stall_ex", 32'(stall_n), 32'h1);
    tick();
    chk("t7_bubble_e_ir", e_ir_n, 32'h0);
    chk("t7_stall_mm", 32'(stall_n), 32'h1);
    tick();
    chk("t7_stall_wb", 32'(stall_n), 32'h0);
    tick();
    chk("t7_add_e_ir", e_ir_n, enc_add(2, 1, 0));
    chk("t7_add_fwd_a", 32'(fwd_a_n), 32'h0);
    chk("t7_add_fwd_b", 32'(fwd_b_n), 32'h0);
    chk("t7_stall_cnt", 32'(stall_cnt_n), 32'd2);
    chk("t7_issue", 32'(issue_cnt_n), 32'd2);
    put_n(32'h0, 1'b0);

    // Saturating two-bit counters
    do_reset();
    for (int i = 0; i < 5; i++) begin
      put_s(32'h0, 1'b1);
      tick();
      chk($sformatf("t8_issue_sat_%0d", i), 32'(issue_cnt_s), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    for (int i = 0; i < 4; i++) begin
      put_s(enc_lw(1, 0, 0), 1'b1);
      tick();
      put_s(enc_addi(2, 1, 0), 1'b1);
      tick();
      tick();
      chk($sformatf("t8_stall_sat_%0d", i), 32'(stall_cnt_s), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    chk("t8_issue_held", 32'(issue_cnt_s), 32'd3);
    put_s(32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
